debounce_multi: RTL and testbench
=================================

# debounce_multi

Parametrised multi-channel debouncer for push-button and switch inputs. Each channel has:
- a synchroniser;
- an independent 4-state debounce FSM driven by a shared millisecond-scale tick;
- registered level, rise and fall outputs.

It runs in one of two modes: lockout (immediate response, then ignore input for the debounce window) or qualify (output changes only after the input has been stable for the full window). It sits between raw board inputs and the control logic, and replaces the single-channel fixed-count debouncer.

## Interface
- N_CH, 4: number of independent channels (≥1)
- SYNC_STAGES, 2: synchroniser flops per channel (≥2)
- TICK_DIV, 50_000: clk cycles per debounce tick (≥1; 50_000 = 1 ms at 50 MHz; 1 = tick every cycle)
- DB_TICKS, 20: ticks per debounce window (≥1)
- MODE, 1: 0 = lockout, 1 = qualify
- clk  input  1  system clock; one clock, all logic on posedge
- n_rst  input  1  asynchronous, active-low reset
- din  input  N_CH  raw asynchronous inputs
- dout  output  N_CH  debounced levels, registered
- rise  output  N_CH  one-cycle pulse when dout[i] goes 0→1
- fall  output  N_CH  one-cycle pulse when dout[i] goes 1→0
- any_event  output  1  one-cycle pulse, OR of all rise|fall bits, registered same cycle as them

## Operation
- Synchroniser: a SYNC_STAGES-deep chain per channel, reset to 0. Its output is s[i].
- Tick generator: a free-running counter of width $clog2(TICK_DIV), reset to 0. `tick` is high when the counter equals TICK_DIV-1; the counter then wraps to 0. The tick is shared by all channels.
- Per-channel FSM states: S_ZERO, S_WAIT1, S_ONE, S_WAIT0. Reset state is S_ZERO.
- Per-channel counter: width $clog2(DB_TICKS+1).
  - Cleared on the cycle of entry into a WAIT state.
  - Increments on each tick in cycles strictly after entry.
- Window end: in a WAIT state, `tick` with cnt == DB_TICKS-1 completes the window. The window length is therefore (DB_TICKS-1)*TICK_DIV+1 to DB_TICKS*TICK_DIV cycles.
- Transitions:
  - S_ZERO → S_WAIT1 when s=1.
  - S_ONE → S_WAIT0 when s=0.
  - S_WAIT1 → S_ONE at window end.
  - S_WAIT0 → S_ZERO at window end.
- MODE 0 (lockout):
  - dout is 1 in S_WAIT1 and S_ONE, and 0 otherwise.
  - s is ignored in WAIT states.
- MODE 1 (qualify):
  - dout is 1 in S_ONE and S_WAIT0, and 0 otherwise.
  - In S_WAIT1, s=0 aborts to S_ZERO. In S_WAIT0, s=1 aborts to S_ONE.
  - An abort and a window end in the same cycle: the abort wins and dout is unchanged.
- rise, fall and any_event are registered. They assert in the same cycle that dout changes, for exactly one cycle.
- Channels are fully independent. Simultaneous events on several channels produce simultaneous pulses and a single any_event pulse.
- Unreachable or illegal state: go to S_ZERO with dout=0.

## Timing
- Reset (async assert): dout, rise, fall and any_event are all 0. All FSMs are in S_ZERO, all counters are 0, the tick counter is 0 and the synchronisers are 0. Reset is released synchronously by the board-level reset logic.
- din edge to s: SYNC_STAGES cycles.
- MODE 0 press: dout and rise appear 1 cycle after s changes, i.e. SYNC_STAGES+1 cycles after the din edge.
- MODE 1 press: dout and rise appear at window end + 1 cycle after s changes.
- Reset mid-window: the window is discarded. After release, a held din restarts a full window from S_ZERO.
- No backpressure: outputs are levels and pulses with no handshake.

## Structure
- Shared package debounce_pkg:
  - state encodings S_ZERO=2'b00, S_WAIT0=2'b01, S_ONE=2'b10, S_WAIT1=2'b11;
  - MODE_LOCKOUT=0 and MODE_QUALIFY=1.
- Sub-module debounce_ch contains one channel: the FSM, the window counter and the dout/rise/fall registers. It takes tick and s as inputs and is instantiated N_CH times in a generate loop.
- The top level holds the synchronisers, the tick generator and the any_event register.

## Test plan
Bench parameters: N_CH=4, SYNC_STAGES=2, TICK_DIV=4, DB_TICKS=3, both MODE values.
- Reset: hold n_rst=0 with din=4'hF toggling → all outputs 0, no pulses, throughout reset and for 2 cycles after release.
- MODE 1 clean press: din[0] 0→1 held → dout[0] rises 3 + (9..12) cycles after the edge; exactly one rise[0] and one any_event pulse; dout[3:1]=0.
- MODE 1 bounce: din[0] toggles every 3 cycles for 30 cycles, then held 1 → dout[0] stays 0 during bouncing, then rises exactly once; fall[0] never pulses.
- MODE 0 lockout: din[0] 0→1 → dout[0]=1 exactly 3 cycles later. 1-cycle glitches to 0 within the window are ignored. A release after the window gives dout[0]=0 3 cycles later with a single fall[0].
- Multi-channel: din[1] and din[3] rise in the same cycle → rise[1] and rise[3] pulse in the same cycle; any_event is a single 1-cycle pulse.
- Reset mid-window (MODE 0, dout[2]=1 in S_WAIT1): n_rst=0 → dout[2]=0 without waiting for a clock edge. After release with din[2] held 1, dout[2]=1 again 3 cycles later and a full window follows.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel debouncer: FSM state encoding,
// operating-mode constants and the state-to-level mapping used by every channel.
package debounce_pkg;

  typedef enum logic [1:0] {
    S_ZERO  = 2'b00,
    S_WAIT0 = 2'b01,
    S_ONE   = 2'b10,
    S_WAIT1 = 2'b11
  } db_state_e;

  localparam int MODE_LOCKOUT = 0;
  localparam int MODE_QUALIFY = 1;

  // Debounced level presented while a channel sits in a given state.
  // Lockout reports the new level as soon as the window opens.
  // Qualify keeps reporting the old level until the window has completed.
  function automatic logic dout_level(input db_state_e st, input int mode);
    logic lvl;
    if (mode == MODE_LOCKOUT) begin
      lvl = (st == S_WAIT1) || (st == S_ONE);
    end else begin
      lvl = (st == S_ONE) || (st == S_WAIT0);
    end
    return lvl;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 4-state FSM, window counter and the registered
// level / rise / fall outputs. The synchronised input and the shared tick
// come from the top level.
module debounce_ch
  import debounce_pkg::*;
#(
  parameter int DB_TICKS = 20,
  parameter int MODE     = MODE_QUALIFY
) (
  input  logic clk,
  input  logic n_rst,
  input  logic tick_i,
  input  logic s_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic evt_nxt_o
);

  localparam int              CW       = $clog2(DB_TICKS + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_TICKS - 1);
  localparam logic            QUALIFY  = (MODE == MODE_QUALIFY);

  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dout_q, dout_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;
  logic          win_end;

  // Next-state and window-counter logic; an abort takes priority over a
  // window end, so a bounce on the last tick never changes the level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_end = tick_i && (cnt_q == CNT_LAST);
    case (state_q)
      S_ZERO: begin
        if (s_i) begin
          state_d = S_WAIT1;
          cnt_d   = '0;
        end
      end
      S_ONE: begin
        if (!s_i) begin
          state_d = S_WAIT0;
          cnt_d   = '0;
        end
      end
      S_WAIT1: begin
        if (QUALIFY && !s_i) begin
          state_d = S_ZERO;
        end else if (win_end) begin
          state_d = S_ONE;
        end else if (tick_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT0: begin
        if (QUALIFY && s_i) begin
          state_d = S_ONE;
        end else if (win_end) begin
          state_d = S_ZERO;
        end else if (tick_i) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_ZERO;
        cnt_d   = '0;
      end
    endcase
  end

  // Output levels follow the next state so dout and its edge pulses are
  // registered on the same clock as the state change.
  always_comb begin
    dout_d = dout_level(state_d, MODE);
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  // State, counter and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= S_ZERO;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign dout_o    = dout_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  // Unregistered edge indication so the top can register any_event on the
  // same clock as rise/fall.
  assign evt_nxt_o = rise_d | fall_d;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: per-channel synchronisers, the shared tick
// generator, N_CH debounce channels and the combined any_event register.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 50_000,
  parameter int DB_TICKS    = 20,
  parameter int MODE        = MODE_QUALIFY
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [N_CH-1:0] din,
  output logic [N_CH-1:0] dout,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall,
  output logic            any_event
);

  // A divide-by-one tick still needs a one-bit counter that never leaves 0.
  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;
  logic [TW-1:0]   tdiv_q, tdiv_d;
  logic            tick;
  logic [N_CH-1:0] evt_nxt;
  logic            any_q, any_d;

  // Synchroniser chains for the raw asynchronous inputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Free-running tick divider; the tick is high on its terminal count.
  always_comb begin
    tick   = (tdiv_q == TICK_LAST);
    tdiv_d = tick ? '0 : tdiv_q + 1'b1;
  end

  // Tick divider register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tdiv_q <= '0;
    end else begin
      tdiv_q <= tdiv_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_ch #(
      .DB_TICKS (DB_TICKS),
      .MODE     (MODE)
    ) u_ch (
      .clk       (clk),
      .n_rst     (n_rst),
      .tick_i    (tick),
      .s_i       (s[i]),
      .dout_o    (dout[i]),
      .rise_o    (rise[i]),
      .fall_o    (fall[i]),
      .evt_nxt_o (evt_nxt[i])
    );
  end

  // Simultaneous edges on several channels collapse into one any_event.
  always_comb begin
    any_d = |evt_nxt;
  end

  // any_event register, aligned with the per-channel rise/fall registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      any_q <= 1'b0;
    end else begin
      any_q <= any_d;
    end
  end

  assign any_event = any_q;

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: one qualify-mode and one lockout-mode
// instance sharing clock and reset.
module tb_debounce_multi;

  localparam int N_CH = 4;

  logic            clk   = 1'b0;
  logic            n_rst = 1'b1;
  logic [N_CH-1:0] din_m0 = '0;
  logic [N_CH-1:0] din_m1 = '0;
  logic [N_CH-1:0] dout_m0, rise_m0, fall_m0;
  logic [N_CH-1:0] dout_m1, rise_m1, fall_m1;
  logic            any_m0, any_m1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(4), .DB_TICKS(3), .MODE(0)
  ) u_dut_m0 (
    .clk(clk), .n_rst(n_rst), .din(din_m0),
    .dout(dout_m0), .rise(rise_m0), .fall(fall_m0), .any_event(any_m0)
  );

  debounce_multi #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(4), .DB_TICKS(3), .MODE(1)
  ) u_dut_m1 (
    .clk(clk), .n_rst(n_rst), .din(din_m1),
    .dout(dout_m1), .rise(rise_m1), .fall(fall_m1), .any_event(any_m1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    n_rst  = 1'b0;
    din_m0 = '0;
    din_m1 = '0;
    repeat (2) step();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [25:0] outs;
    n_rst  = 1'b0;
    din_m0 = 4'hF;
    din_m1 = 4'hF;
    for (int c = 0; c < 8; c++) begin
      step();
      outs = {dout_m0, rise_m0, fall_m0, any_m0, dout_m1, rise_m1, fall_m1, any_m1};
      tests++;
      if (outs !== '0) begin
        fails++;
        $display("FAIL reset_hold c=%0d: got %h expected 0", c, outs);
      end
      din_m0 = ~din_m0;
      din_m1 = ~din_m1;
    end
    din_m0 = '0;
    din_m1 = '0;
    n_rst  = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      outs = {dout_m0, rise_m0, fall_m0, any_m0, dout_m1, rise_m1, fall_m1, any_m1};
      tests++;
      if (outs !== '0) begin
        fails++;
        $display("FAIL reset_release c=%0d: got %h expected 0", c, outs);
      end
    end
  endtask

  task automatic test_qualify_press();
    int first = 0, rises = 0, falls = 0, anys = 0, bad_other = 0;
    logic rise_at_first = 1'b0;
    apply_reset();
    din_m1 = 4'b0001;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (rise_m1[0]) rises++;
      if (fall_m1[0]) falls++;
      if (any_m1) anys++;
      if (dout_m1[3:1] !== 3'b000) bad_other++;
      if (dout_m1[0] === 1'b1 && first == 0) begin
        first = c;
        rise_at_first = rise_m1[0];
      end
    end
    tests++;
    if (first < 12 || first > 15) begin
      fails++;
      $display("FAIL q_press_latency: got %0d cycles expected 12..15", first);
    end
    tests++;
    if (rises != 1 || rise_at_first !== 1'b1) begin
      fails++;
      $display("FAIL q_press_rise: got %0d pulses (at_edge=%b) expected 1 at edge", rises, rise_at_first);
    end
    tests++;
    if (anys != 1 || falls != 0) begin
      fails++;
      $display("FAIL q_press_events: got any=%0d fall=%0d expected any=1 fall=0", anys, falls);
    end
    tests++;
    if (bad_other != 0 || dout_m1 !== 4'b0001) begin
      fails++;
      $display("FAIL q_press_others: got bad=%0d dout=%b expected 0 and 0001", bad_other, dout_m1);
    end
  endtask

  task automatic test_qualify_bounce();
    int bad = 0, first = 0, rises = 0, falls = 0;
    apply_reset();
    for (int seg = 0; seg < 10; seg++) begin
      din_m1[0] = (seg % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        step();
        if (dout_m1[0] !== 1'b0) bad++;
        if (rise_m1[0]) rises++;
        if (fall_m1[0]) falls++;
      end
    end
    tests++;
    if (bad != 0 || rises != 0) begin
      fails++;
      $display("FAIL q_bounce_quiet: got high=%0d rise=%0d expected 0 0", bad, rises);
    end
    din_m1[0] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (rise_m1[0]) rises++;
      if (fall_m1[0]) falls++;
      if (dout_m1[0] === 1'b1 && first == 0) first = c;
    end
    tests++;
    if (first < 12 || first > 15) begin
      fails++;
      $display("FAIL q_bounce_latency: got %0d cycles expected 12..15", first);
    end
    tests++;
    if (rises != 1 || falls != 0) begin
      fails++;
      $display("FAIL q_bounce_pulses: got rise=%0d fall=%0d expected 1 0", rises, falls);
    end
  endtask

  task automatic test_lockout();
    int bad = 0, rises = 0, falls = 0;
    apply_reset();
    din_m0 = 4'b0001;
    for (int c = 1; c <= 3; c++) begin
      step();
      tests++;
      if (dout_m0[0] !== (c == 3) || rise_m0[0] !== (c == 3) || any_m0 !== (c == 3)) begin
        fails++;
        $display("FAIL lo_press c=%0d: got dout=%b rise=%b any=%b expected %0d", c, dout_m0[0], rise_m0[0], any_m0, (c == 3));
      end
    end
    for (int c = 4; c <= 20; c++) begin
      if (c == 4 || c == 7) din_m0[0] = 1'b0;
      if (c == 5 || c == 8) din_m0[0] = 1'b1;
      step();
      if (dout_m0[0] !== 1'b1 || rise_m0[0] || fall_m0[0]) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL lo_glitch: got %0d disturbed cycles expected 0", bad);
    end
    din_m0[0] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      step();
      tests++;
      if (dout_m0[0] !== (c != 3) || fall_m0[0] !== (c == 3)) begin
        fails++;
        $display("FAIL lo_release c=%0d: got dout=%b fall=%b expected dout=%0d", c, dout_m0[0], fall_m0[0], (c != 3));
      end
    end
    for (int c = 0; c < 20; c++) begin
      step();
      if (rise_m0[0]) rises++;
      if (fall_m0[0]) falls++;
      if (dout_m0[0] !== 1'b0) bad++;
    end
    tests++;
    if (rises != 0 || falls != 0 || bad != 0) begin
      fails++;
      $display("FAIL lo_after_release: got rise=%0d fall=%0d high=%0d expected 0 0 0", rises, falls, bad);
    end
  endtask

  task automatic test_multi_channel();
    int bad = 0, anys_m1 = 0;
    logic [N_CH-1:0] first_rise_m1 = '0;
    logic [N_CH-1:0] exp_rise, exp_dout;
    logic            exp_any;
    apply_reset();
    din_m0 = 4'b1010;
    din_m1 = 4'b1010;
    for (int c = 1; c <= 40; c++) begin
      step();
      exp_rise = (c == 3) ? 4'b1010 : 4'b0000;
      exp_any  = (c == 3);
      exp_dout = (c >= 3) ? 4'b1010 : 4'b0000;
      if (c == 3) begin
        tests++;
        if (rise_m0 !== exp_rise || any_m0 !== exp_any) begin
          fails++;
          $display("FAIL multi_m0_edge: got rise=%b any=%b expected 1010 1", rise_m0, any_m0);
        end
      end else if (rise_m0 !== exp_rise || any_m0 !== exp_any || dout_m0 !== exp_dout || fall_m0 !== 4'b0000) begin
        bad++;
      end
      if (any_m1) anys_m1++;
      if (rise_m1 !== 4'b0000 && first_rise_m1 === 4'b0000) first_rise_m1 = rise_m1;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL multi_m0_other: got %0d wrong cycles expected 0", bad);
    end
    tests++;
    if (first_rise_m1 !== 4'b1010 || anys_m1 != 1) begin
      fails++;
      $display("FAIL multi_m1: got rise=%b any_pulses=%0d expected 1010 1", first_rise_m1, anys_m1);
    end
  endtask

  task automatic test_reset_mid_window();
    int bad = 0, fall_at = 0, falls = 0;
    apply_reset();
    din_m0 = 4'b0100;
    repeat (3) step();
    tests++;
    if (dout_m0 !== 4'b0100) begin
      fails++;
      $display("FAIL mid_setup: got %b expected 0100", dout_m0);
    end
    step();
    #3;
    n_rst = 1'b0;
    #1;
    tests++;
    if ({dout_m0, rise_m0, fall_m0, any_m0} !== '0) begin
      fails++;
      $display("FAIL mid_async_reset: got dout=%b rise=%b fall=%b any=%b expected 0", dout_m0, rise_m0, fall_m0, any_m0);
    end
    repeat (2) step();
    n_rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      tests++;
      if (dout_m0[2] !== (c == 3) || rise_m0[2] !== (c == 3)) begin
        fails++;
        $display("FAIL mid_restart c=%0d: got dout=%b rise=%b expected %0d", c, dout_m0[2], rise_m0[2], (c == 3));
      end
    end
    din_m0[2] = 1'b0;
    for (int c = 4; c <= 20; c++) begin
      step();
      if (c <= 12 && dout_m0[2] !== 1'b1) bad++;
      if (fall_m0[2]) begin
        falls++;
        if (fall_at == 0) fall_at = c;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL mid_full_window: got %0d early-low cycles expected 0", bad);
    end
    tests++;
    if (falls != 1 || fall_at < 13 || fall_at > 16 || dout_m0[2] !== 1'b0) begin
      fails++;
      $display("FAIL mid_window_end: got falls=%0d at=%0d dout=%b expected 1 at 13..16 dout 0", falls, fall_at, dout_m0[2]);
    end
  endtask

  initial begin
    test_reset();
    test_qualify_press();
    test_qualify_bounce();
    test_lockout();
    test_multi_channel();
    test_reset_mid_window();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
